// File: rtl/rpn_engine.sv
// rtl/rpn_engine.sv - RPN calculator engine driven by a 4x4 numpad key code
module rpn_engine #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [4:0]                   key,
  output logic [WIDTH-1:0]             top,
  output logic [WIDTH-1:0]             next,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         error
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(WIDTH + 1);
  localparam int DW = WIDTH + 4;
  localparam int PW = 2 * WIDTH;

  typedef enum logic {IDLE, MUL_RUN} state_t;
  typedef enum logic [2:0] {
    OP_DIGIT, OP_ENTER, OP_ADD, OP_SUB, OP_MUL, OP_CLEAR, OP_DROP
  } op_t;

  state_t state, state_nx;
  op_t    op;
  logic [3:0] digit;

  // top and next live in dedicated registers; deeper entries sit in lower[]
  logic [WIDTH-1:0] lower [DEPTH];
  logic [4:0]       prev_key;

  logic [IW-1:0]    mul_iter;
  logic [PW-1:0]    mul_acc;
  logic [PW-1:0]    mul_mcand;
  logic [WIDTH-1:0] mul_mplier;
  logic [PW-1:0]    mul_acc_nx;

  logic             accepted, clear_hit, act, mul_start, mul_last;
  logic [DW-1:0]    digit_val;
  logic             digit_ovf;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             sub_ok;
  logic [AW-1:0]    rd_idx, wr_idx;
  logic [WIDTH-1:0] below;

  // a press counts once: new when the previous sample was released or a different key
  assign accepted  = key[4] && (!prev_key[4] || (prev_key[3:0] != key[3:0]));
  assign clear_hit = accepted && (op == OP_CLEAR);
  assign act       = accepted && (state == IDLE) && !error && (op != OP_CLEAR);
  assign mul_start = act && (op == OP_MUL) && (count >= CW'(2));
  assign mul_last  = (state == MUL_RUN) && (mul_iter == IW'(WIDTH - 1));

  assign rd_idx = AW'(count - CW'(3));
  assign wr_idx = AW'(count - CW'(2));
  assign below  = (count >= CW'(3)) ? lower[rd_idx] : '0;

  // key id to operation and digit value
  always_comb begin
    op    = OP_DIGIT;
    digit = 4'd0;
    case (key[3:0])
      4'h0: digit = 4'd1;
      4'h1: digit = 4'd4;
      4'h2: digit = 4'd7;
      4'h3: digit = 4'd0;
      4'h4: digit = 4'd2;
      4'h5: digit = 4'd5;
      4'h6: digit = 4'd8;
      4'h7: op    = OP_CLEAR;
      4'h8: digit = 4'd3;
      4'h9: digit = 4'd6;
      4'hA: digit = 4'd9;
      4'hB: op    = OP_DROP;
      4'hC: op    = OP_ENTER;
      4'hD: op    = OP_ADD;
      4'hE: op    = OP_SUB;
      4'hF: op    = OP_MUL;
      default: digit = 4'd0;
    endcase
  end

  // arithmetic candidates, each with its own overflow/legality flag
  always_comb begin
    digit_val  = ({4'b0, top} * DW'(10)) + DW'(digit);
    digit_ovf  = |digit_val[DW-1:WIDTH];
    sum        = {1'b0, next} + {1'b0, top};
    diff       = next - top;
    sub_ok     = (next >= top);
    mul_acc_nx = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next state: multiply runs until the last iteration or a CLEAR
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (mul_start) state_nx = MUL_RUN;
      MUL_RUN: if (clear_hit || mul_last) state_nx = IDLE;
    endcase
  end

  // datapath: key sample, top/next/count, error, multiplier iteration
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_key   <= '0;
      top        <= '0;
      next       <= '0;
      count      <= CW'(1);
      busy       <= 1'b0;
      error      <= 1'b0;
      mul_iter   <= '0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
    end else begin
      prev_key <= key;
      busy     <= (state_nx == MUL_RUN);
      if (clear_hit) begin
        top   <= '0;
        next  <= '0;
        count <= CW'(1);
        error <= 1'b0;
      end else if (state == MUL_RUN) begin
        mul_acc    <= mul_acc_nx;
        mul_mcand  <= mul_mcand << 1;
        mul_mplier <= mul_mplier >> 1;
        mul_iter   <= mul_iter + IW'(1);
        if (mul_last) begin
          if (mul_acc_nx[PW-1:WIDTH] == '0) begin
            top   <= mul_acc_nx[WIDTH-1:0];
            next  <= below;
            count <= count - CW'(1);
          end else begin
            error <= 1'b1;
          end
        end
      end else if (act) begin
        case (op)
          OP_DIGIT: begin
            if (digit_ovf) error <= 1'b1;
            else           top   <= digit_val[WIDTH-1:0];
          end
          OP_ENTER: begin
            if (count == CW'(DEPTH)) begin
              error <= 1'b1;
            end else begin
              next  <= top;
              top   <= '0;
              count <= count + CW'(1);
            end
          end
          OP_ADD: begin
            if ((count < CW'(2)) || sum[WIDTH]) begin
              error <= 1'b1;
            end else begin
              top   <= sum[WIDTH-1:0];
              next  <= below;
              count <= count - CW'(1);
            end
          end
          OP_SUB: begin
            if ((count < CW'(2)) || !sub_ok) begin
              error <= 1'b1;
            end else begin
              top   <= diff;
              next  <= below;
              count <= count - CW'(1);
            end
          end
          OP_MUL: begin
            if (count < CW'(2)) begin
              error <= 1'b1;
            end else begin
              mul_acc    <= '0;
              mul_mcand  <= {{WIDTH{1'b0}}, next};
              mul_mplier <= top;
              mul_iter   <= '0;
            end
          end
          OP_DROP: begin
            if (count > CW'(1)) begin
              top   <= next;
              next  <= below;
              count <= count - CW'(1);
            end else begin
              top <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // spill the old next into deeper storage when ENTER pushes
  always_ff @(posedge clock) begin
    if (!reset && act && (op == OP_ENTER) && (count >= CW'(2)) && (count != CW'(DEPTH)))
      lower[wr_idx] <= next;
  end

endmodule

// File: tb/tb_rpn_engine.sv
// tb/tb_rpn_engine.sv - randomized and directed self-check of rpn_engine against a stack model
module tb_rpn_engine;

  localparam logic [4:0] K0 = 5'h13, K1 = 5'h10, K2 = 5'h14, K4 = 5'h11, K5 = 5'h15;
  localparam logic [4:0] K3 = 5'h18, K6 = 5'h19, K7 = 5'h12, K9 = 5'h1A;
  localparam logic [4:0] KENT = 5'h1C, KADD = 5'h1D, KSUB = 5'h1E, KMUL = 5'h1F;
  localparam logic [4:0] KCLR = 5'h17;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [4:0] key = '0;

  logic [31:0] top0, next0, top1, next1;
  logic [7:0]  top2, next2;
  logic [4:0]  count0, count2;
  logic [2:0]  count1;
  logic        busy0, busy1, busy2, error0, error1, error2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  rpn_engine #(.WIDTH(32), .DEPTH(16)) u0 (.clock(clock), .reset(reset), .key(key),
    .top(top0), .next(next0), .count(count0), .busy(busy0), .error(error0));
  rpn_engine #(.WIDTH(32), .DEPTH(4)) u1 (.clock(clock), .reset(reset), .key(key),
    .top(top1), .next(next1), .count(count1), .busy(busy1), .error(error1));
  rpn_engine #(.WIDTH(8), .DEPTH(16)) u2 (.clock(clock), .reset(reset), .key(key),
    .top(top2), .next(next2), .count(count2), .busy(busy2), .error(error2));

  logic [63:0] dt[3], dn[3], dc[3], db[3], de[3];
  always_comb begin
    dt[0] = 64'(top0);  dn[0] = 64'(next0); dc[0] = 64'(count0); db[0] = 64'(busy0); de[0] = 64'(error0);
    dt[1] = 64'(top1);  dn[1] = 64'(next1); dc[1] = 64'(count1); db[1] = 64'(busy1); de[1] = 64'(error1);
    dt[2] = 64'(top2);  dn[2] = 64'(next2); dc[2] = 64'(count2); db[2] = 64'(busy2); de[2] = 64'(error2);
  end

  // behavioural model: a plain array stack per instance, values held as 64-bit integers
  bit [63:0]  m_stk [3][0:15];
  int         m_sz [3];
  bit         m_err [3];
  int         m_busy [3];
  bit [63:0]  m_pend [3];
  logic [4:0] m_prev;

  function automatic int mw(int u);
    return (u == 2) ? 8 : 32;
  endfunction

  function automatic int md(int u);
    return (u == 1) ? 4 : 16;
  endfunction

  function automatic int digit_of(logic [3:0] id);
    case (id)
      4'h0: return 1;  4'h1: return 4;  4'h2: return 7;  4'h3: return 0;
      4'h4: return 2;  4'h5: return 5;  4'h6: return 8;
      4'h8: return 3;  4'h9: return 6;  4'hA: return 9;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(int u, bit acc, logic [3:0] id);
    bit [63:0] mask, t, b, r;
    mask = (64'd1 << mw(u)) - 64'd1;
    t = m_stk[u][m_sz[u]-1];
    b = (m_sz[u] >= 2) ? m_stk[u][m_sz[u]-2] : 64'd0;
    if (acc && id == 4'h7) begin
      m_sz[u] = 1; m_stk[u][0] = 0; m_err[u] = 0; m_busy[u] = 0;
    end else if (m_busy[u] > 0) begin
      m_busy[u]--;
      if (m_busy[u] == 0) begin
        if (m_pend[u] > mask) m_err[u] = 1;
        else begin m_sz[u]--; m_stk[u][m_sz[u]-1] = m_pend[u]; end
      end
    end else if (acc && !m_err[u]) begin
      case (id)
        4'hC: if (m_sz[u] == md(u)) m_err[u] = 1;
              else begin m_stk[u][m_sz[u]] = 0; m_sz[u]++; end
        4'hD: begin
          r = b + t;
          if (m_sz[u] < 2 || r > mask) m_err[u] = 1;
          else begin m_sz[u]--; m_stk[u][m_sz[u]-1] = r; end
        end
        4'hE: if (m_sz[u] < 2 || b < t) m_err[u] = 1;
              else begin m_sz[u]--; m_stk[u][m_sz[u]-1] = b - t; end
        4'hF: if (m_sz[u] < 2) m_err[u] = 1;
              else begin m_busy[u] = mw(u); m_pend[u] = b * t; end
        4'hB: if (m_sz[u] > 1) m_sz[u]--; else m_stk[u][0] = 0;
        default: begin
          r = t * 10 + 64'(digit_of(id));
          if (r > mask) m_err[u] = 1; else m_stk[u][m_sz[u]-1] = r;
        end
      endcase
    end
  endtask

  always @(posedge clock) begin
    bit acc;
    acc = key[4] && (!m_prev[4] || m_prev[3:0] != key[3:0]);
    if (reset) begin
      m_prev = '0;
      for (int u = 0; u < 3; u++) begin
        m_sz[u] = 1; m_stk[u][0] = 0; m_err[u] = 0; m_busy[u] = 0;
      end
    end else begin
      for (int u = 0; u < 3; u++) model_step(u, acc, key[3:0]);
      m_prev = key;
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, required %0d", nm, $time, act, exp);
    end
  endtask

  task automatic compare();
    for (int u = 0; u < 3; u++) begin
      bit [63:0] mt, mn;
      mt = m_stk[u][m_sz[u]-1];
      mn = (m_sz[u] >= 2) ? m_stk[u][m_sz[u]-2] : 64'd0;
      chk($sformatf("u%0d.top", u),   dt[u], mt);
      chk($sformatf("u%0d.next", u),  dn[u], mn);
      chk($sformatf("u%0d.count", u), dc[u], 64'(m_sz[u]));
      chk($sformatf("u%0d.busy", u),  db[u], 64'(m_busy[u] > 0));
      chk($sformatf("u%0d.error", u), de[u], 64'(m_err[u]));
    end
  endtask

  task automatic cycle(input logic [4:0] k);
    key = k;
    @(posedge clock);
    @(negedge clock);
    compare();
  endtask

  task automatic press(input logic [4:0] k);
    repeat (3) cycle(k);
    cycle(5'h00);
  endtask

  initial begin
    int nb, nb2;
    reset = 1'b1;
    cycle(5'h00);
    cycle(5'h00);
    reset = 1'b0;
    chk("reset.top", dt[0], 0);     chk("reset.next", dn[0], 0);
    chk("reset.count", dc[0], 1);   chk("reset.busy", db[0], 0);
    chk("reset.error", de[0], 0);

    press(K1);  chk("held1.top", dt[0], 1);
    press(K2);  chk("held2.top", dt[0], 12);
    press(KENT); press(K3); press(K4); press(KADD);
    chk("add.top", dt[0], 46); chk("add.count", dc[0], 1); chk("add.error", de[0], 0);

    press(KCLR); press(K7); press(KENT); press(K9); press(KSUB);
    chk("sub.error", de[0], 1); chk("sub.top", dt[0], 9); chk("sub.count", dc[0], 2);
    press(KADD);
    chk("ign.top", dt[0], 9); chk("ign.count", dc[0], 2);
    press(KCLR);
    chk("clr.top", dt[0], 0); chk("clr.count", dc[0], 1); chk("clr.error", de[0], 0);

    press(K1); press(K2); press(KENT); press(K1); press(K1);
    nb = 0;
    key = KMUL;
    for (int i = 0; i < 60; i++) begin
      logic [4:0] k;
      k = (i < 3) ? KMUL : ((i == 10 || i == 11) ? K5 : 5'h00);
      cycle(k);
      if (busy0) nb++;
    end
    chk("mul.busy_cycles", 64'(nb), 32);
    chk("mul.top", dt[0], 132); chk("mul.count", dc[0], 1);

    press(KCLR); press(KENT); press(KENT); press(KENT);
    chk("d4.count3", dc[1], 4); chk("d4.err3", de[1], 0);
    press(KENT);
    chk("d4.err4", de[1], 1); chk("d4.count4", dc[1], 4);

    press(KCLR); press(K2); press(K5); press(K5);
    chk("w8.top255", dt[2], 255);
    press(K0);
    chk("w8.ovf_err", de[2], 1); chk("w8.ovf_top", dt[2], 255);
    press(KCLR); press(K1); press(K6); press(KENT); press(K1); press(K6);
    nb2 = 0;
    for (int i = 0; i < 40; i++) begin
      cycle((i < 3) ? KMUL : 5'h00);
      if (busy2) nb2++;
    end
    chk("w8.mul_busy", 64'(nb2), 8); chk("w8.mul_err", de[2], 1);
    chk("w8.mul_top", dt[2], 16); chk("w8.mul_count", dc[2], 2);
    chk("w32.mul_256", dt[0], 256);

    press(KCLR); press(K1); press(K2); press(KENT); press(K1); press(K1);
    nb = 0;
    for (int i = 0; i < 40 && nb < 10; i++) begin
      cycle((i < 3) ? KMUL : 5'h00);
      if (busy0) nb++;
    end
    chk("rst.reached10", 64'(nb), 10);
    reset = 1'b1;
    cycle(5'h00);
    reset = 1'b0;
    chk("rst.busy", db[0], 0); chk("rst.count", dc[0], 1); chk("rst.top", dt[0], 0);

    reset = 1'b1;
    cycle(K7);
    reset = 1'b0;
    cycle(K7);
    cycle(K7);
    chk("held_through_reset.top", dt[0], 7);
    cycle(5'h00);

    for (int s = 0; s < 2500; s++) begin
      logic [4:0] k;
      int hold;
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        cycle(5'h00);
        reset = 1'b0;
      end
      k = ($urandom_range(0, 9) < 4) ? 5'h00 : {1'b1, 4'($urandom)};
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) cycle(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
